// File: rtl/jb_aes_pkg.sv
// -----------------------------------------------------------------------------
// jb_aes_pkg
//   Shared types and constants for the AES pipe scheduler family.
//   - AES_BLOCK_WIDTH : AES block / key width in bits
//   - MAX_NREQ        : largest requester count a scheduler may be built with
//   - TAG_ID_W        : requester id width carried in a pipe tag (sized for
//                       MAX_NREQ so one tag type serves every NREQ)
//   - sched_tag_t     : {valid, id} travelling alongside the AES pipe
//   - sched_state_t   : scheduler quiesce state machine
// -----------------------------------------------------------------------------
package jb_aes_pkg;

    localparam int AES_BLOCK_WIDTH = 128;
    localparam int MAX_NREQ        = 8;
    localparam int TAG_ID_W        = $clog2(MAX_NREQ);

    typedef struct packed {
        logic                valid;
        logic [TAG_ID_W-1:0] id;
    } sched_tag_t;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_DRAIN   = 2'd1,
        ST_DRAINED = 2'd2
    } sched_state_t;

endpackage

// File: rtl/jb_rr_arbiter.sv
// -----------------------------------------------------------------------------
// jb_rr_arbiter
//   NREQ-wide round-robin arbiter. The search starts at the internal pointer
//   and wraps at NREQ; the first requesting index wins. The pointer moves to
//   the winner + 1 (mod NREQ) whenever a grant is issued and holds otherwise.
//   Ports:
//     clk, rst      : clock, synchronous active-high reset (pointer -> 0)
//     en            : grants allowed this cycle
//     req[NREQ]     : request vector
//     grant[NREQ]   : one-hot grant (zero when en=0 or no request)
//     grant_valid   : any grant issued
//     grant_id      : index of the granted requester
// -----------------------------------------------------------------------------
module jb_rr_arbiter #(
    parameter int NREQ = 2,
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] grant,
    output logic            grant_valid,
    output logic [IDW-1:0]  grant_id
);

    logic [IDW-1:0] ptr_reg;
    logic [IDW-1:0] ptr_next;

    // base + off reduced modulo NREQ; off never exceeds NREQ so one subtract
    // is enough.
    function automatic logic [IDW-1:0] wrap_idx(input logic [IDW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NREQ) begin
            s = s - NREQ;
        end
        return IDW'(s);
    endfunction

    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        grant_id    = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (en && !grant_valid && req[wrap_idx(ptr_reg, k)]) begin
                grant_valid                   = 1'b1;
                grant_id                      = wrap_idx(ptr_reg, k);
                grant[wrap_idx(ptr_reg, k)]   = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_next = ptr_reg;
        if (grant_valid) begin
            ptr_next = wrap_idx(grant_id, 1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_reg <= '0;
        end else begin
            ptr_reg <= ptr_next;
        end
    end

endmodule

// File: rtl/jb_aes_pipe_sched.sv
// -----------------------------------------------------------------------------
// jb_aes_pipe_sched
//   Shares one fully pipelined AES encrypt core between NREQ requesters.
//   One block per cycle is accepted from the round-robin winner and driven
//   into the pipe; a tag shift register of PIPE_LATENCY stages follows the
//   pipe so each ciphertext is steered back to its owner. A drain handshake
//   stops acceptance and reports when the pipe is empty.
//   Optional build macro: JB_AES_SCHED_STATS_EN adds per-requester 32-bit
//   accept and wait counters (stat_accepts, stat_waits).
//   Ports:
//     clk, rst               : clock, synchronous active-high reset
//     req_valid/req_ready    : per-requester handshake (ready is one-hot/zero)
//     req_key/req_block      : per-requester key and plaintext
//     pipe_key/pipe_blockin  : to the AES pipe (zero when nothing accepted)
//     pipe_blockout          : from the AES pipe
//     rsp_valid/rsp_block    : one-hot response and shared ciphertext
//     drain_req/drain_done   : quiesce request / pipe empty and held
//     busy                   : at least one block in flight
// -----------------------------------------------------------------------------
module jb_aes_pipe_sched
    import jb_aes_pkg::*;
#(
    parameter int BLOCK_WIDTH  = AES_BLOCK_WIDTH,
    parameter int NREQ         = 2,
    parameter int PIPE_LATENCY = 11,
    localparam int IDW         = (NREQ > 1) ? $clog2(NREQ) : 1,
    localparam int CNT_W       = $clog2(PIPE_LATENCY + 1)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NREQ-1:0]                 req_valid,
    output logic [NREQ-1:0]                 req_ready,
    input  logic [NREQ-1:0][BLOCK_WIDTH-1:0] req_key,
    input  logic [NREQ-1:0][BLOCK_WIDTH-1:0] req_block,
    output logic [BLOCK_WIDTH-1:0]          pipe_key,
    output logic [BLOCK_WIDTH-1:0]          pipe_blockin,
    input  logic [BLOCK_WIDTH-1:0]          pipe_blockout,
    output logic [NREQ-1:0]                 rsp_valid,
    output logic [BLOCK_WIDTH-1:0]          rsp_block,
    input  logic                            drain_req,
    output logic                            drain_done,
    output logic                            busy
`ifdef JB_AES_SCHED_STATS_EN
    ,
    output logic [NREQ-1:0][31:0]           stat_accepts,
    output logic [NREQ-1:0][31:0]           stat_waits
`endif
);

    sched_state_t     state_reg;
    sched_state_t     state_next;
    logic             accept;
    logic [IDW-1:0]   grant_id;
    sched_tag_t       tag_in;
    sched_tag_t       tag_last;
    logic [CNT_W-1:0] inflight_reg;
    logic [CNT_W-1:0] inflight_next;

    // ---------------------------------------------------------------- arbiter
    jb_rr_arbiter #(
        .NREQ(NREQ)
    ) u_arb (
        .clk        (clk),
        .rst        (rst),
        .en         (state_reg == ST_RUN),
        .req        (req_valid),
        .grant      (req_ready),
        .grant_valid(accept),
        .grant_id   (grant_id)
    );

    always_comb begin
        pipe_key     = '0;
        pipe_blockin = '0;
        if (accept) begin
            pipe_key     = req_key[grant_id];
            pipe_blockin = req_block[grant_id];
        end
    end

    // ------------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_RUN;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        drain_done = 1'b0;
        case (state_reg)
            ST_RUN: begin
                if (drain_req) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // A withdrawn drain request wins over an empty pipe.
                if (!drain_req) begin
                    state_next = ST_RUN;
                end else if (inflight_reg == '0) begin
                    state_next = ST_DRAINED;
                end
            end
            ST_DRAINED: begin
                drain_done = 1'b1;
                if (!drain_req) begin
                    state_next = ST_RUN;
                end
            end
            default: begin
                state_next = ST_RUN;
            end
        endcase
    end

    // ------------------------------------------------------- tag shift chain
    // The chain never stalls: it advances in lockstep with the AES pipe, so
    // the last stage lines up with pipe_blockout.
    assign tag_in.valid = accept;
    assign tag_in.id    = TAG_ID_W'(grant_id);

    genvar gi;
    generate
        for (gi = 0; gi < PIPE_LATENCY; gi++) begin : g_tag
            sched_tag_t stage_reg;
            if (gi == 0) begin : g_head
                always_ff @(posedge clk) begin
                    if (rst) begin
                        stage_reg <= '0;
                    end else begin
                        stage_reg <= tag_in;
                    end
                end
            end else begin : g_body
                always_ff @(posedge clk) begin
                    if (rst) begin
                        stage_reg <= '0;
                    end else begin
                        stage_reg <= g_tag[gi-1].stage_reg;
                    end
                end
            end
        end
    endgenerate

    assign tag_last = g_tag[PIPE_LATENCY-1].stage_reg;

    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_rsp
            assign rsp_valid[gi] = tag_last.valid && (tag_last.id == TAG_ID_W'(gi));
        end
    endgenerate

    // Pipe data belonging to blocks whose tags were cleared by reset is masked.
    assign rsp_block = tag_last.valid ? pipe_blockout : '0;

    // ------------------------------------------------------ in-flight count
    always_comb begin
        inflight_next = inflight_reg;
        case ({accept, tag_last.valid})
            2'b10:   inflight_next = inflight_reg + CNT_W'(1);
            2'b01:   inflight_next = inflight_reg - CNT_W'(1);
            default: inflight_next = inflight_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_reg <= '0;
        end else begin
            inflight_reg <= inflight_next;
        end
    end

    assign busy = (inflight_reg != '0);

`ifdef JB_AES_SCHED_STATS_EN
    // ------------------------------------------------------------ statistics
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_stat
            logic [31:0] accepts_reg;
            logic [31:0] waits_reg;
            always_ff @(posedge clk) begin
                if (rst) begin
                    accepts_reg <= '0;
                    waits_reg   <= '0;
                end else begin
                    if (req_ready[gi]) begin
                        accepts_reg <= accepts_reg + 32'd1;
                    end
                    if (req_valid[gi] && !req_ready[gi]) begin
                        waits_reg <= waits_reg + 32'd1;
                    end
                end
            end
            assign stat_accepts[gi] = accepts_reg;
            assign stat_waits[gi]   = waits_reg;
        end
    endgenerate
`endif

endmodule

// File: tb/tb_jb_aes_pipe_sched.sv
// -----------------------------------------------------------------------------
// tb_jb_aes_pipe_sched
//   Bench for jb_aes_pipe_sched with a behavioural AES-128 pipe model and a
//   transaction-level scheduler reference (round-robin search, response queue
//   keyed by due cycle, drain rules expressed over drain_req history).
//   Define JB_AES_SCHED_STATS_EN to also exercise the statistics counters.
// -----------------------------------------------------------------------------
module tb_jb_aes_pipe_sched;

    localparam int BW   = 128;
    localparam int NREQ = 2;
    localparam int L    = 11;

    logic                    clk;
    logic                    rst;
    logic [NREQ-1:0]         req_valid;
    logic [NREQ-1:0]         req_ready;
    logic [NREQ-1:0][BW-1:0] req_key;
    logic [NREQ-1:0][BW-1:0] req_block;
    logic [BW-1:0]           pipe_key;
    logic [BW-1:0]           pipe_blockin;
    logic [BW-1:0]           pipe_blockout;
    logic [NREQ-1:0]         rsp_valid;
    logic [BW-1:0]           rsp_block;
    logic                    drain_req;
    logic                    drain_done;
    logic                    busy;
`ifdef JB_AES_SCHED_STATS_EN
    logic [NREQ-1:0][31:0]   stat_accepts;
    logic [NREQ-1:0][31:0]   stat_waits;
`endif

    jb_aes_pipe_sched #(
        .BLOCK_WIDTH (BW),
        .NREQ        (NREQ),
        .PIPE_LATENCY(L)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_key      (req_key),
        .req_block    (req_block),
        .pipe_key     (pipe_key),
        .pipe_blockin (pipe_blockin),
        .pipe_blockout(pipe_blockout),
        .rsp_valid    (rsp_valid),
        .rsp_block    (rsp_block),
        .drain_req    (drain_req),
        .drain_done   (drain_done),
        .busy         (busy)
`ifdef JB_AES_SCHED_STATS_EN
        ,
        .stat_accepts (stat_accepts),
        .stat_waits   (stat_waits)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------ AES model
    logic [7:0] sbox [256];

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p = 8'h00; aa = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = xt(aa);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] d;
        d = {b, b} << n;
        return d[15:8];
    endfunction

    initial begin
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    end

    function automatic logic [127:0] aes_enc(input logic [127:0] key, input logic [127:0] pt);
        logic [31:0]  w [44];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [31:0]  tmp;
        logic [7:0]   rc, a0, a1, a2, a3;
        logic [127:0] res;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {sbox[tmp[23:16]], sbox[tmp[15:8]], sbox[tmp[7:0]], sbox[tmp[31:24]]} ^ {rc, 24'h0};
                rc  = xt(rc);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8];
        for (int r = 0; r <= 10; r++) begin
            if (r > 0) begin
                for (int i = 0; i < 16; i++) t[i] = sbox[s[i]];
                for (int c = 0; c < 4; c++)
                    for (int rw = 0; rw < 4; rw++)
                        s[rw+4*c] = t[rw + 4*((c+rw) % 4)];
                if (r < 10) begin
                    for (int c = 0; c < 4; c++) begin
                        a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                        s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                        s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                        s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                        s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
                    end
                end
            end
            for (int c = 0; c < 4; c++)
                for (int bi = 0; bi < 4; bi++)
                    s[4*c+bi] = s[4*c+bi] ^ w[4*r+c][31-8*bi -: 8];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    // Behavioural pipe: result of the block sampled at an edge appears on
    // blockout L-1 edges later, i.e. in the response cycle of its tag.
    logic [BW-1:0] pipe_q [L];
    always @(posedge clk) begin
        pipe_q[0] <= ((pipe_key | pipe_blockin) != '0) ? aes_enc(pipe_key, pipe_blockin) : '0;
        for (int k = 1; k < L; k++) pipe_q[k] <= pipe_q[k-1];
    end
    assign pipe_blockout = pipe_q[L-1];

    // ------------------------------------------------------ reference model
    typedef struct {
        int           due;
        int           id;
        logic [127:0] ct;
    } rsp_t;

    rsp_t            exp_q [$];
    int              cyc;
    int              m_ptr;
    bit              m_accepting;
    bit              m_prev_dr;
    bit              m_done;
    int              n_checks;
    int              n_pass;
    int              n_acc_seen;
    int              n_rsp_seen;
    logic [NREQ-1:0] last_rsp_v;
    logic [BW-1:0]   last_rsp_blk;
    int              last_rsp_cyc;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Called at a falling edge with inputs already applied; checks this
    // cycle, advances the model and returns at the next falling edge.
    task automatic run_cycle();
        logic [NREQ-1:0] exp_ready, exp_rv;
        logic [BW-1:0]   exp_blk, exp_pk, exp_pb;
        int              gid, qs0, cand;
        bit              next_done;
        #1;
        qs0 = exp_q.size();
        gid = -1;
        if (m_accepting) begin
            for (int k = 0; k < NREQ; k++) begin
                cand = (m_ptr + k) % NREQ;
                if (gid < 0 && req_valid[cand]) gid = cand;
            end
        end
        exp_ready = '0;
        exp_pk    = '0;
        exp_pb    = '0;
        if (gid >= 0) begin
            exp_ready[gid] = 1'b1;
            exp_pk = req_key[gid];
            exp_pb = req_block[gid];
        end
        exp_rv  = '0;
        exp_blk = '0;
        if (qs0 > 0 && exp_q[0].due == cyc) begin
            exp_rv[exp_q[0].id] = 1'b1;
            exp_blk = exp_q[0].ct;
            void'(exp_q.pop_front());
        end
        chk("req_ready", req_ready, exp_ready);
        chk("pipe_key", pipe_key, exp_pk);
        chk("pipe_blockin", pipe_blockin, exp_pb);
        chk("rsp_valid", rsp_valid, exp_rv);
        chk("rsp_block", rsp_block, exp_blk);
        chk("busy", busy, (qs0 != 0));
        chk("drain_done", drain_done, m_done);
        if (req_ready != '0) n_acc_seen++;
        if (rsp_valid != '0) begin
            n_rsp_seen++;
            last_rsp_v   = rsp_valid;
            last_rsp_blk = rsp_block;
            last_rsp_cyc = cyc;
            $display("cyc=%0d rsp mask=%b ct=%h", cyc, rsp_valid, rsp_block);
        end
        if (gid >= 0) begin
            exp_q.push_back('{due: cyc + L, id: gid, ct: aes_enc(req_key[gid], req_block[gid])});
            m_ptr = (gid + 1) % NREQ;
        end
        // Held-drained needs a request held over two edges with nothing in
        // flight at the second-to-last one.
        next_done   = drain_req && (m_done || (m_prev_dr && qs0 == 0));
        m_accepting = !drain_req;
        m_prev_dr   = drain_req;
        m_done      = next_done;
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset(input int ncyc);
        rst       = 1'b1;
        req_valid = '0;
        drain_req = 1'b0;
        repeat (ncyc) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        m_ptr       = 0;
        m_accepting = 1'b1;
        m_prev_dr   = 1'b0;
        m_done      = 1'b0;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ----------------------------------------------------------- vectors
    typedef struct {
        int           id;
        logic [127:0] key;
        logic [127:0] pt;
        logic [127:0] ct;
    } vec_t;

    vec_t vecs [4];

    initial begin
        int acc_cyc, a0, r0;
        logic [NREQ-1:0] oh;

        vecs[0] = '{0, 128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3243f6a8885a308d313198a2e0370734, 128'h3925841d02dc09fbdc118597196a0b32};
        vecs[1] = '{1, 128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff, 128'h69c4e0d86a7b0430d8cdb78070b4c55a};
        vecs[2] = '{0, 128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h6bc1bee22e409f96e93d7e117393172a, 128'h3ad77bb40d7a3660a89ecaf32466ef97};
        vecs[3] = '{1, 128'h000102030405060708090a0b0c0d0e0f, 128'h3243f6a8885a308d313198a2e0370734, 128'h0};
        vecs[3].ct = 128'h0;

        n_checks = 0; n_pass = 0; cyc = 0;
        n_acc_seen = 0; n_rsp_seen = 0;
        last_rsp_v = '0; last_rsp_blk = '0; last_rsp_cyc = -1;
        req_key = '0; req_block = '0;
        rst = 1'b1; req_valid = '0; drain_req = 1'b0;
        @(negedge clk);
        do_reset(2);

        // Reset state with idle inputs.
        repeat (3) run_cycle();

        // Known-answer vectors, one block at a time.
        for (int v = 0; v < 3; v++) begin
            req_key[vecs[v].id]   = vecs[v].key;
            req_block[vecs[v].id] = vecs[v].pt;
            oh = '0;
            oh[vecs[v].id] = 1'b1;
            req_valid = oh;
            acc_cyc = cyc;
            run_cycle();
            req_valid = '0;
            repeat (L) run_cycle();
            chk("vec_rsp_valid", last_rsp_v, oh);
            chk("vec_ct", last_rsp_blk, vecs[v].ct);
            chk("vec_latency", last_rsp_cyc, acc_cyc + L);
        end

        // Both requesters streaming for 6 cycles with different keys.
        do_reset(1);
        req_key[0] = vecs[0].key;
        req_key[1] = vecs[1].key;
        for (int k = 0; k < 6; k++) begin
            req_valid = 2'b11;
            req_block[0] = rnd128();
            req_block[1] = rnd128();
            run_cycle();
        end
        req_valid = '0;
        repeat (L + 1) run_cycle();

        // Drain during a full stream, then resume.
        for (int k = 0; k < 6; k++) begin
            req_valid = 2'b11;
            req_block[k % 2] = rnd128();
            run_cycle();
        end
        a0 = n_acc_seen;
        drain_req = 1'b1;
        for (int k = 0; k < L + 4; k++) begin
            req_block[k % 2] = rnd128();
            run_cycle();
        end
        chk("drain_accepts", a0 + 1, n_acc_seen);
        chk("drain_done_held", drain_done, 1'b1);
        drain_req = 1'b0;
        run_cycle();
        a0 = n_acc_seen;
        run_cycle();
        chk("drain_resume", n_acc_seen - a0, 1);
        req_valid = '0;
        repeat (L + 1) run_cycle();

        // Reset with 5 blocks in flight: their responses must vanish.
        for (int k = 0; k < 5; k++) begin
            req_valid = 2'b11;
            req_block[k % 2] = rnd128();
            run_cycle();
        end
        do_reset(1);
        r0 = n_rsp_seen;
        repeat (L + 3) run_cycle();
        chk("post_reset_rsp", n_rsp_seen - r0, 0);
        req_valid = 2'b11;
        run_cycle();
        req_valid = '0;
        repeat (L) run_cycle();

        // Randomized traffic with occasional drain toggles and key changes.
        for (int k = 0; k < 400; k++) begin
            req_valid = NREQ'($urandom_range(0, (1 << NREQ) - 1));
            for (int r = 0; r < NREQ; r++) begin
                req_block[r] = rnd128();
                if ($urandom_range(0, 7) == 0) req_key[r] = rnd128();
            end
            if ($urandom_range(0, 24) == 0) drain_req = ~drain_req;
            run_cycle();
        end
        drain_req = 1'b0;
        req_valid = '0;
        repeat (L + 2) run_cycle();

`ifdef JB_AES_SCHED_STATS_EN
        // Requester 1 held while requester 0 streams for 4 cycles.
        do_reset(1);
        for (int k = 0; k < 4; k++) begin
            req_valid = 2'b11;
            run_cycle();
        end
        req_valid = '0;
        chk("stat_waits1", stat_waits[1], 32'd2);
        chk("stat_accepts0", stat_accepts[0], 32'd2);
        repeat (L + 1) run_cycle();
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/jb_aes_pipe_sched.md
# jb_aes_pipe_sched

Round-robin scheduler that shares one fully pipelined AES encryption core among `NREQ` requesters. It accepts one block per cycle from the winning requester and drives that requester's key and plaintext into the pipe. A tag shift register runs alongside the pipe, so each ciphertext returns to its owner exactly `PIPE_LATENCY` cycles later. The block sits between client logic (for example a CTR/ECB front end) and `JB_AES_Encrypt_Pipe`. It also provides a drain handshake for safe quiescing.

## Interface
- `BLOCK_WIDTH`, 128, AES block and key width in bits
- `NREQ`, 2, number of requesters (2..8)
- `PIPE_LATENCY`, 11, cycles from the pipe sampling `blockin` to the matching `blockout` being valid
- `clk`  in  1  clock; all logic on the rising edge
- `rst`  in  1  reset, synchronous and active-high
- `req_valid`  in  NREQ  requester i has a block
- `req_ready`  out  NREQ  requester i's block is accepted this cycle
- `req_key`  in  NREQ×BLOCK_WIDTH  per-requester key
- `req_block`  in  NREQ×BLOCK_WIDTH  per-requester plaintext
- `pipe_key`  out  BLOCK_WIDTH  to pipe `key`
- `pipe_blockin`  out  BLOCK_WIDTH  to pipe `blockin`
- `pipe_blockout`  in  BLOCK_WIDTH  from pipe `blockout`
- `rsp_valid`  out  NREQ  one-hot; ciphertext for requester i this cycle
- `rsp_block`  out  BLOCK_WIDTH  ciphertext, shared by all requesters
- `drain_req`  in  1  stop accepting and empty the pipe
- `drain_done`  out  1  high while drained (DRAINED state)
- `busy`  out  1  at least one block in flight

## Operation
- FSM states: RUN, DRAIN, DRAINED. Reset enters RUN.
  - RUN → DRAIN when `drain_req`=1.
  - DRAIN → DRAINED when the in-flight count is 0.
  - DRAINED → RUN when `drain_req`=0.
  - DRAIN → RUN when `drain_req` drops before the pipe is empty.
- Arbitration (RUN only):
  - Grant the first i with `req_valid[i]`, searching from `rr_ptr` upward with wrap at NREQ.
  - `req_ready` is one-hot or zero and combinational from `req_valid`, `rr_ptr` and state.
  - On accept, `rr_ptr` ← granted index + 1, mod NREQ.
  - With no accept, `rr_ptr` holds.
- Pipe drive (combinational):
  - On accept: `pipe_key`/`pipe_blockin` = the granted requester's key and block.
  - Otherwise: both outputs are 0.
- Tag shift register:
  - `PIPE_LATENCY` stages, each holding {valid, id[$clog2(NREQ)-1:0]}.
  - Stage 0 loads {accept, grant id}. All stages shift every cycle; there is no stall.
  - Final stage drives `rsp_valid` (decoded one-hot) and qualifies `rsp_block` = `pipe_blockout`.
  - `rsp_block` is 0 when no response is valid.
- In-flight counter:
  - Width $clog2(PIPE_LATENCY+1).
  - +1 on accept, −1 on final-stage valid; both in the same cycle leaves it unchanged.
  - Never exceeds PIPE_LATENCY.
  - `busy` = counter ≠ 0.
- Responses have no backpressure. Requesters must sink `rsp_valid` unconditionally.

## Timing
- Reset values:
  - `req_ready`=0, `rsp_valid`=0, `rsp_block`=0, `pipe_key`=0, `pipe_blockin`=0.
  - `drain_done`=0, `busy`=0.
  - `rr_ptr`=0, all tag valid bits 0, counter 0.
- Throughput: one accept per cycle, sustained.
- Latency: a block accepted at edge E is reported with `rsp_valid` high in the cycle after edge E+PIPE_LATENCY.
- Drain:
  - `drain_req` sampled 1 at edge E forces `req_ready`=0 from the cycle after E onward.
  - An accept in the same cycle as the `drain_req` assertion still completes.
  - `drain_done` rises in the cycle after the counter reaches 0.
- Reset mid-operation: all in-flight tags are discarded. No `rsp_valid` appears for pre-reset blocks, even though the pipe still holds their data.
- Wrap: when `rr_ptr` = NREQ−1 and NREQ−1 is granted, `rr_ptr` becomes 0.

## Configuration
- `JB_AES_SCHED_STATS_EN`:
  - Defined: adds per-requester 32-bit `stat_accepts[i]` and `stat_waits[i]` outputs.
    - `stat_waits[i]` increments on cycles with `req_valid[i]`=1 and `req_ready[i]`=0.
    - Both counters wrap at 2^32, and reset to 0 on `rst`.
  - Undefined: those ports and counters do not exist.

## Structure
- Shared package `jb_aes_pkg`:
  - Block-width constant.
  - Tag typedef {valid, id}.
  - Scheduler state enum.
- Sub-module `jb_rr_arbiter`: NREQ-wide round-robin with pointer update, reused by future decrypt scheduling.

## Test plan
- Single request, FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 on requester 0.
  - Required: `rsp_valid`=2'b01 exactly PIPE_LATENCY cycles after accept, `rsp_block`=3925841d02dc09fbdc118597196a0b32.
- Both requesters hold `req_valid` for 6 cycles.
  - Required: grants alternate 0,1,0,1,0,1; responses return in the same order with correct ids; `busy` stays 1 throughout.
- Requester 1 uses a key different from requester 0's, with blocks interleaved.
  - Required: each ciphertext matches the reference model for that requester's own key.
- Assert `drain_req` during a full stream.
  - Required: no accepts after one cycle; exactly the in-flight responses are delivered; `drain_done` rises one cycle after the counter reaches 0.
  - Then deassert `drain_req`: acceptance resumes the next cycle.
- Assert `rst` for one cycle with 5 blocks in flight.
  - Required: zero `rsp_valid` afterward; `busy`=0; `rr_ptr`=0.
- With stats enabled: hold requester 1 valid while requester 0 also streams for 4 cycles.
  - Required: `stat_waits[1]`=2 and `stat_accepts[0]`=2.
